// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] DEF_NOP_INSTR = 32'h0000_0000;
  localparam logic [WORD_W-1:0] DEF_PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    STALL,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] upc;
    logic              valid;
  } fetch_entry_t;

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return addr & {{(WORD_W-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and memory.
interface if_fetch_unit_if;
  import fetch_pkg::*;

  logic              IMemReq;
  logic [WORD_W-1:0] IMemAddr;
  logic              IMemAck;
  logic [WORD_W-1:0] IMemData;

  modport master (
    output IMemReq,
    output IMemAddr,
    input  IMemAck,
    input  IMemData
  );

  modport slave (
    input  IMemReq,
    input  IMemAddr,
    output IMemAck,
    output IMemData
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// Two-entry output buffer: the slot presented to IF/ID plus a one-entry skid behind it.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [WORD_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              consume,
  input  logic              load,
  input  logic [WORD_W-1:0] load_instr,
  input  logic [WORD_W-1:0] load_upc,
  output logic [WORD_W-1:0] slot_instr,
  output logic [WORD_W-1:0] slot_upc,
  output logic              slot_valid,
  output logic              skid_valid
);

  fetch_entry_t slot_reg;
  fetch_entry_t skid_reg;
  fetch_entry_t in_entry;

  assign in_entry = '{instr: load_instr, upc: load_upc, valid: 1'b1};

  // Invalidation keeps the slot's upc so UpdatedPC holds its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_reg <= '{instr: NOP_INSTR, upc: RESET_PC, valid: 1'b0};
      skid_reg <= '{instr: NOP_INSTR, upc: RESET_PC, valid: 1'b0};
    end else if (flush) begin
      slot_reg.instr <= NOP_INSTR;
      slot_reg.valid <= 1'b0;
      skid_reg.valid <= 1'b0;
    end else if (consume) begin
      if (skid_reg.valid) begin
        slot_reg <= skid_reg;
        if (load) begin
          skid_reg <= in_entry;
        end else begin
          skid_reg.valid <= 1'b0;
        end
      end else if (load) begin
        slot_reg <= in_entry;
      end else begin
        slot_reg.instr <= NOP_INSTR;
        slot_reg.valid <= 1'b0;
      end
    end else if (load) begin
      if (!slot_reg.valid) begin
        slot_reg <= in_entry;
      end else begin
        skid_reg <= in_entry;
      end
    end
  end

  assign slot_instr = slot_reg.instr;
  assign slot_upc   = slot_reg.upc;
  assign slot_valid = slot_reg.valid;
  assign skid_valid = skid_reg.valid;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, memory handshake FSM and slot/skid buffering.
// Optional FETCH_MISALIGN_CHK_EN flags branch targets that are not word aligned.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [WORD_W-1:0] NOP_INSTR = DEF_NOP_INSTR,
  parameter logic [WORD_W-1:0] PC_STEP   = DEF_PC_STEP
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Hold,
  input  logic                  BranchTaken,
  input  logic [WORD_W-1:0]     BranchTarget,
  if_fetch_unit_if.master       imem,
  output logic [WORD_W-1:0]     Instruction,
  output logic [WORD_W-1:0]     UpdatedPC,
  output logic                  InstrValid,
  output logic                  Misaligned
);

  fetch_state_t      state_reg, state_next;
  logic [WORD_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [WORD_W-1:0] addr_reg, addr_next;
  logic              req_reg, req_next;

  logic              ack;
  logic              consume;
  logic              load;
  logic              flush;
  logic              slot_valid;
  logic              skid_valid;
  logic [WORD_W-1:0] target;
  logic [WORD_W-1:0] load_upc;

  assign ack      = imem.IMemAck & req_reg;
  assign consume  = slot_valid & ~Hold;
  assign target   = word_align(BranchTarget);
  assign load_upc = addr_reg + PC_STEP;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg    <= BOOT;
      fetch_pc_reg <= RESET_PC;
      addr_reg     <= RESET_PC;
      req_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      addr_reg     <= addr_next;
      req_reg      <= req_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    load          = 1'b0;
    flush         = 1'b0;

    if (BranchTaken) begin
      // An unacked request must still complete on the bus; its data is thrown away.
      flush         = 1'b1;
      fetch_pc_next = target;
      state_next    = (req_reg && !imem.IMemAck) ? DRAIN : FETCH;
    end else begin
      case (state_reg)
        BOOT: begin
          state_next = FETCH;
        end
        FETCH: begin
          if (ack) begin
            load          = 1'b1;
            fetch_pc_next = fetch_pc_reg + PC_STEP;
            if (slot_valid && !(consume && !skid_valid)) begin
              state_next = STALL;
            end
          end
        end
        STALL: begin
          if (consume && skid_valid) begin
            state_next = FETCH;
          end
        end
        DRAIN: begin
          if (ack) begin
            state_next = FETCH;
          end
        end
        default: begin
          state_next = BOOT;
        end
      endcase
    end

    req_next  = (state_next == FETCH) || (state_next == DRAIN);
    addr_next = (state_next == DRAIN) ? addr_reg : fetch_pc_next;
  end

  assign imem.IMemReq  = req_reg;
  assign imem.IMemAddr = addr_reg;

  fetch_skid_buf #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) u_skid_buf (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .flush      (flush),
    .consume    (consume),
    .load       (load),
    .load_instr (imem.IMemData),
    .load_upc   (load_upc),
    .slot_instr (Instruction),
    .slot_upc   (UpdatedPC),
    .slot_valid (slot_valid),
    .skid_valid (skid_valid)
  );

  assign InstrValid = slot_valid;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misaligned_reg;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      misaligned_reg <= 1'b0;
    end else begin
      misaligned_reg <= BranchTaken & (|BranchTarget[1:0]);
    end
  end

  assign Misaligned = misaligned_reg;
`else
  assign Misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: variable-latency memory model plus an in-order program stream reference.
module tb_if_fetch_unit;

  logic        Clk;
  logic        Rst_n;
  logic        Hold;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic [31:0] Instruction;
  logic [31:0] UpdatedPC;
  logic        InstrValid;
  logic        Misaligned;

  if_fetch_unit_if imem();

  if_fetch_unit dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Hold         (Hold),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .imem         (imem),
    .Instruction  (Instruction),
    .UpdatedPC    (UpdatedPC),
    .InstrValid   (InstrValid),
    .Misaligned   (Misaligned)
  );

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] SALT = 32'hA5A5_0000;
`ifdef FETCH_MISALIGN_CHK_EN
  localparam logic MIS_ON = 1'b1;
`else
  localparam logic MIS_ON = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int n_consumed = 0;

  // Reference state: next program-order instruction address, next request address.
  logic [31:0] exp_pc;
  logic [31:0] exp_start;
  logic        exp_mis;
  logic        pend;
  logic [31:0] pend_addr;
  logic        last_start;
  logic [31:0] last_start_addr;
  int          wait_cnt;
  int          cur_lat;
  int          lat_mode;
  int          since_rst;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc     = 32'h0;
    exp_start  = 32'h0;
    exp_mis    = 1'b0;
    pend       = 1'b0;
    pend_addr  = 32'h0;
    last_start = 1'b0;
    wait_cnt   = 0;
    cur_lat    = 1;
    since_rst  = 0;
    imem.IMemAck  = 1'b0;
    imem.IMemData = 32'h0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_req"},   {31'b0, imem.IMemReq}, 32'h0);
    chk({tag, "_addr"},  imem.IMemAddr, 32'h0);
    chk({tag, "_instr"}, Instruction, NOP);
    chk({tag, "_upc"},   UpdatedPC, 32'h0);
    chk({tag, "_valid"}, {31'b0, InstrValid}, 32'h0);
    chk({tag, "_mis"},   {31'b0, Misaligned}, 32'h0);
  endtask

  // One clock: drive inputs, play memory, check outputs against the reference, advance.
  task automatic cyc(input logic hold, input logic br, input logic [31:0] tgt);
    logic start;
    logic ack;
    Hold = hold;
    BranchTaken = br;
    BranchTarget = tgt;
    chk("misaligned", {31'b0, Misaligned}, {31'b0, exp_mis});
    if (pend) begin
      chk("req_stable", {31'b0, imem.IMemReq}, 32'h1);
      chk("addr_stable", imem.IMemAddr, pend_addr);
    end
    start = imem.IMemReq && !pend;
    last_start = start;
    last_start_addr = imem.IMemAddr;
    if (start) begin
      chk("req_addr", imem.IMemAddr, exp_start);
      exp_start = exp_start + 32'd4;
      wait_cnt = 0;
      cur_lat = (lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode;
    end
    ack = 1'b0;
    if (imem.IMemReq) begin
      wait_cnt++;
      ack = (wait_cnt >= cur_lat);
    end
    imem.IMemAck  = ack;
    imem.IMemData = ack ? (imem.IMemAddr ^ SALT) : 32'hDEAD_BEEF;
    if (InstrValid) begin
      chk("instr", Instruction, exp_pc ^ SALT);
      chk("upc", UpdatedPC, exp_pc + 32'd4);
    end else begin
      chk("nop", Instruction, NOP);
    end
    if (br) begin
      exp_pc = tgt & ~32'h3;
      exp_start = tgt & ~32'h3;
    end else if (InstrValid && !hold) begin
      exp_pc = exp_pc + 32'd4;
      n_consumed++;
    end
    pend = imem.IMemReq && !ack;
    pend_addr = imem.IMemAddr;
    exp_mis = br && (tgt[1:0] != 2'b00) && MIS_ON;
    @(posedge Clk);
    @(negedge Clk);
    since_rst++;
  endtask

  initial begin
    logic found;
    Rst_n = 1'b0;
    Hold = 1'b0;
    BranchTaken = 1'b0;
    BranchTarget = 32'h0;
    lat_mode = 1;
    model_reset();

    // Reset state, then release and check startup timing with zero-wait memory.
    @(negedge Clk);
    chk_reset_values("rst");
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("boot_req", {31'b0, imem.IMemReq}, (since_rst >= 1) ? 32'h1 : 32'h0);
      chk("boot_valid", {31'b0, InstrValid}, (since_rst >= 2) ? 32'h1 : 32'h0);
      cyc(1'b0, 1'b0, 32'h0);
    end

    // Hold for five cycles: skid fills, request drops, stream resumes in order.
    for (int h = 0; h < 5; h++) begin
      if (h >= 1) chk("stall_req", {31'b0, imem.IMemReq}, 32'h0);
      cyc(1'b1, 1'b0, 32'h0);
    end
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 32'h0);

    // Three-cycle latency streaming.
    lat_mode = 3;
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 32'h0);

    // Branch to 0x100 while the 0x20 fetch is still waiting.
    cyc(1'b0, 1'b1, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      cyc(1'b0, 1'b0, 32'h0);
      found = last_start && (last_start_addr == 32'h20);
    end
    chk("reach_0x20", {31'b0, found}, 32'h1);
    cyc(1'b0, 1'b1, 32'h100);
    chk("drain_invalid0", {31'b0, InstrValid}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("drain_invalid1", {31'b0, InstrValid}, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc(1'b1, 1'b0, 32'h0);
      found = InstrValid;
    end
    chk("br_upc", UpdatedPC, 32'h104);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 32'h0);

    // Misaligned target.
    lat_mode = 1;
    cyc(1'b0, 1'b1, 32'h102);
    chk("mis_pulse", {31'b0, Misaligned}, {31'b0, MIS_ON});
    cyc(1'b0, 1'b0, 32'h0);
    chk("mis_clear", {31'b0, Misaligned}, 32'h0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 32'h0);

    // Address wrap past 0xFFFF_FFFC.
    cyc(1'b0, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 32'h0);

    // Asynchronous reset in the middle of a slow fetch.
    lat_mode = 3;
    cyc(1'b0, 1'b1, 32'h40);
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    #2;
    Rst_n = 1'b0;
    #1;
    chk_reset_values("midrst");
    model_reset();
    @(negedge Clk);
    Rst_n = 1'b1;
    lat_mode = 1;
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 32'h0);

    // Randomized traffic.
    lat_mode = 0;
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0, $urandom & 32'h0000_0FFF);
    end
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 32'h0);
    chk("consumed_enough", {31'b0, n_consumed > 200}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage directly upstream of the IF/ID pipeline register. Holds the program counter, issues word fetches to instruction memory over a req/ack handshake, and buffers up to two returned instructions. It presents `Instruction`/`UpdatedPC` to IF/ID under the same `Hold`-high-means-freeze convention that IF/ID uses. Taken branches redirect the PC and flush buffered instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0000: value driven on `Instruction` when the output slot is empty.
- `PC_STEP`, default 4: byte increment between sequential fetches.
---
- `Clk`  in  1  single clock, rising edge.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `Hold`  in  1  from the hazard unit; 1 = IF/ID frozen, so the slot is not consumed.
- `BranchTaken`  in  1  one-cycle redirect request.
- `BranchTarget`  in  32  redirect byte address.
- `IMemReq`  out  1  fetch request.
- `IMemAddr`  out  32  fetch byte address.
- `IMemAck`  in  1  response strobe; `IMemData` is valid in the same cycle.
- `IMemData`  in  32  fetched word.
- `Instruction`  out  32  slot instruction to IF/ID.
- `UpdatedPC`  out  32  slot instruction address + `PC_STEP`.
- `InstrValid`  out  1  slot holds a real instruction.
- `Misaligned`  out  1  misaligned-branch flag (see Configuration).

## Operation
- Storage:
  - FetchPC: address of the current or next request.
  - Slot: `Instruction`, `UpdatedPC`, `InstrValid`.
  - Skid: a one-entry buffer with the same fields.
- Consume: asserted at a posedge where `InstrValid=1` and `Hold=0`.
- FSM states:
  - BOOT: `IMemReq=0`; always moves to FETCH.
  - FETCH: `IMemReq=1`, `IMemAddr=FetchPC`.
  - STALL: `IMemReq=0`; skid is full.
  - DRAIN: `IMemReq=1` with the old address; the response will be discarded.
- Handshake: once `IMemReq` rises, `IMemReq` and `IMemAddr` stay stable until the cycle `IMemAck=1`. `IMemAck` while `IMemReq=0` is ignored.
- Ack in FETCH without a branch:
  - FetchPC advances by `PC_STEP`.
  - Data goes to the slot if the slot is empty, or if it is being consumed and the skid is empty.
  - Otherwise data goes to the skid.
  - If the skid becomes full, the next state is STALL; otherwise the FSM stays in FETCH.
- On consume:
  - Slot loads from the skid if the skid is valid.
  - Otherwise slot loads the same-cycle ack data.
  - Otherwise `InstrValid` goes to 0.
- STALL moves to FETCH on the posedge where the skid drains into the slot.
- `BranchTaken=1` has highest priority, regardless of `Hold`:
  - Slot and skid are invalidated and FetchPC is loaded with the target.
  - If a request is outstanding and unacked, the next state is DRAIN. Otherwise the next state is FETCH, and any same-cycle ack data is dropped.
- DRAIN: on ack, the data is dropped and the next state is FETCH at the target. A second branch during DRAIN updates the target and stays in DRAIN.
- When `InstrValid=0`, `Instruction=NOP_INSTR` and `UpdatedPC` is unchanged.
- Arithmetic: 32-bit, wrap-around. `32'hFFFF_FFFC + 4 = 0`, with no flag.

## Timing
- Reset values:
  - `IMemReq=0`, `IMemAddr=RESET_PC`, FetchPC=`RESET_PC`.
  - `Instruction=NOP_INSTR`, `UpdatedPC=RESET_PC`, `InstrValid=0`, skid empty, `Misaligned=0`, state BOOT.
- All outputs are registered. BOOT lasts one cycle; `IMemReq` is first high on the 2nd posedge after `Rst_n` deasserts.
- Zero-wait memory (ack in the request cycle): slot is valid 1 cycle after the request cycle. Sustained throughput is one instruction per cycle while `Hold=0`.
- Branch: the first request at the target is issued the cycle after the branch, or the cycle after the drain ack.
- Reset assertion mid-transaction clears everything immediately. The memory must abandon the request.

## Configuration
- `FETCH_MISALIGN_CHK_EN` defined: a branch target with `[1:0]!=0` still redirects, to `{target[31:2],2'b00}`. `Misaligned` pulses 1 for one cycle, registered with the redirect.
- Not defined: the low bits are silently cleared and `Misaligned` is tied to 0.

## Structure
- `fetch_pkg`:
  - FSM state enum (BOOT, FETCH, STALL, DRAIN).
  - `NOP_INSTR` and `PC_STEP` defaults.
  - Word-width constant 32.
- Sub-module `fetch_skid_buf`: the slot plus skid two-entry buffer, with load/consume/flush inputs. The top level keeps the FSM and PC.

## Test plan
- Reset release, zero-wait memory returning words `addr^32'hA5A5_0000`:
  - Requests go to 0, 4, 8…; `UpdatedPC` reads 4, 8, 12….
  - `InstrValid` is continuous from the 3rd posedge.
- Ack with 3-cycle latency: address is stable for 3 cycles; each instruction is presented exactly once; no duplicates or drops.
- `Hold=1` for 5 cycles during streaming:
  - Skid fills, then `IMemReq` drops (STALL).
  - On release, instructions continue in order with no loss.
- `BranchTaken` with target 32'h100 while a 3-cycle fetch of 32'h20 is pending:
  - The 32'h20 data is discarded and `InstrValid=0` during the drain.
  - Next request is to 32'h100; `UpdatedPC`=32'h104.
- Branch to 32'h102 with `FETCH_MISALIGN_CHK_EN`: fetch from 32'h100 and `Misaligned`=1 for one cycle. Without the macro: fetch from 32'h100 and `Misaligned`=0.
- PC at 32'hFFFF_FFFC: next request is to 32'h0000_0000. Reset asserted mid-wait: outputs return to reset values asynchronously.
